// File: rtl/seven_seg_driver.sv
// Binary-to-BCD display writer for the whack-a-mole board.
// Double-dabble conversion feeding a 4-digit active-low scan.
module seven_seg_driver #(
  parameter int DIGITS  = 4,
  parameter int BIN_W   = 14,
  parameter int MAX_VAL = 9999
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_500hz,
  input  logic              clk_2hz,
  input  logic [BIN_W-1:0]  value,
  input  logic              load,
  input  logic              blank_lz,
  input  logic              blink_en,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W);
  localparam int IW = $clog2(DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    COMMIT
  } state_t;

  state_t state, state_nxt;

  logic [BIN_W-1:0] bin_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    disp_q;
  logic [CW-1:0]    cnt_q;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (load) state_nxt = CONVERT;
      CONVERT: if (cnt_q == CW'(BIN_W - 1)) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign busy = (state != IDLE);

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      disp_q   <= '0;
      overflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            bcd_q <= '0;
            cnt_q <= '0;
            if (value > BIN_W'(MAX_VAL)) begin
              bin_q    <= BIN_W'(MAX_VAL);
              overflow <= 1'b1;
            end else begin
              bin_q    <= value;
              overflow <= 1'b0;
            end
          end
        end
        CONVERT: begin
          bcd_q <= {adj[BW-2:0], bin_q[BIN_W-1]};
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q <= cnt_q + 1'b1;
        end
        COMMIT:  disp_q <= bcd_q;
        default: ;
      endcase
    end
  end

  logic          p500_q;
  logic          scan_on;
  logic          scan_on_nxt;
  logic          rise;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [DIGITS-1:0] lz;
  logic [3:0]        nib;
  logic [6:0]        seg_nxt;
  logic [DIGITS-1:0] an_nxt;
  logic              run;

  // first edge only enables the display so digit 0 shows first
  assign rise        = clk_500hz & ~p500_q;
  assign scan_on_nxt = scan_on | rise;
  assign idx_nxt     = (rise & scan_on) ? idx + 1'b1 : idx;
  assign nib         = disp_q[4*idx_nxt +: 4];

  always_comb begin
    lz  = '0;
    run = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      run   = run & (disp_q[4*i +: 4] == 4'd0);
      lz[i] = run;
    end
  end

  always_comb begin
    unique case (nib)
      4'd0:    seg_nxt = 7'b1000000;
      4'd1:    seg_nxt = 7'b1111001;
      4'd2:    seg_nxt = 7'b0100100;
      4'd3:    seg_nxt = 7'b0110000;
      4'd4:    seg_nxt = 7'b0011001;
      4'd5:    seg_nxt = 7'b0010010;
      4'd6:    seg_nxt = 7'b0000010;
      4'd7:    seg_nxt = 7'b1111000;
      4'd8:    seg_nxt = 7'b0000000;
      4'd9:    seg_nxt = 7'b0010000;
      default: seg_nxt = 7'b1111111;
    endcase
    if (blank_lz && lz[idx_nxt]) seg_nxt = 7'b1111111;
    an_nxt = ~(DIGITS'(1) << idx_nxt);
    if (blink_en && !clk_2hz) an_nxt = '1;
    if (!scan_on_nxt) begin
      seg_nxt = 7'b1111111;
      an_nxt  = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p500_q  <= 1'b0;
      scan_on <= 1'b0;
      idx     <= '0;
      seg     <= 7'b1111111;
      an      <= '1;
    end else begin
      p500_q  <= clk_500hz;
      scan_on <= scan_on_nxt;
      idx     <= idx_nxt;
      seg     <= seg_nxt;
      an      <= an_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_driver.sv
// Randomized bench for seven_seg_driver.
// Reference model works on decimal arithmetic.
module tb_seven_seg_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_500hz;
  logic        clk_2hz;
  logic [13:0] value;
  logic        load;
  logic        blank_lz;
  logic        blink_en;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        busy;
  logic        overflow;

  seven_seg_driver dut (
    .clk       (clk),
    .rst       (rst),
    .clk_500hz (clk_500hz),
    .clk_2hz   (clk_2hz),
    .value     (value),
    .load      (load),
    .blank_lz  (blank_lz),
    .blink_en  (blink_en),
    .seg       (seg),
    .an        (an),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  int n_chk = 0;
  int n_err = 0;
  int m_disp = 0;
  int m_idx = 0;
  bit m_on = 0;
  bit m_ovf = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pow10(input int i);
    int r = 1;
    for (int k = 0; k < i; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg();
    int d;
    if (!m_on) return 7'h7f;
    d = (m_disp / pow10(m_idx)) % 10;
    if (blank_lz && m_idx > 0 && m_disp < pow10(m_idx)) return 7'h7f;
    return seg_tab[d];
  endfunction

  function automatic logic [3:0] exp_an();
    if (!m_on || (blink_en && !clk_2hz)) return 4'hf;
    return ~(4'b0001 << m_idx);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scan_pulse();
    clk_500hz = 1'b1;
    tick();
    if (!m_on) m_on = 1'b1;
    else m_idx = (m_idx + 1) % 4;
    chk("seg", seg, exp_seg());
    chk("an", an, exp_an());
    clk_500hz = 1'b0;
    tick();
    chk("seg_hold", seg, exp_seg());
  endtask

  task automatic scan4();
    for (int i = 0; i < 4; i++) scan_pulse();
  endtask

  task automatic do_load(input int v);
    int n;
    value = 14'(v);
    load = 1'b1;
    tick();
    load = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      tick();
    end
    chk("busy_len", n, 15);
    m_ovf = (v > 9999);
    m_disp = m_ovf ? 9999 : v;
    chk("overflow", overflow, m_ovf);
  endtask

  initial begin
    int rises;
    int highs;
    bit prev;
    rst = 1'b1;
    clk_500hz = 1'b0;
    clk_2hz = 1'b1;
    value = '0;
    load = 1'b0;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    tick();
    tick();
    chk("rst_seg", seg, 7'h7f);
    chk("rst_an", an, 4'hf);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    tick();
    chk("pre_scan_an", an, 4'hf);
    scan_pulse();
    chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 7'b1000000);
    scan4();

    do_load(1234);
    scan4();
    do_load(12000);
    scan4();
    do_load(42);
    scan4();
    blank_lz = 1'b1;
    tick();
    scan4();
    do_load(0);
    scan4();
    blank_lz = 1'b0;

    // second load three cycles into the first conversion is dropped
    value = 14'd5678;
    load = 1'b1;
    tick();
    load = 1'b0;
    rises = 0;
    highs = 0;
    prev = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy && !prev) rises++;
      if (busy) highs++;
      prev = busy;
      if (i == 2) begin
        value = 14'd1111;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    chk("busy_pulses", rises, 1);
    chk("busy_cycles", highs, 15);
    m_disp = 5678;
    m_ovf = 0;
    scan4();

    value = 14'd777;
    load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ovf", overflow, 0);
    m_disp = 0;
    m_idx = 0;
    m_on = 0;
    m_ovf = 0;
    chk("abort_seg", seg, 7'h7f);
    chk("abort_an", an, 4'hf);
    tick();
    chk("abort_idle", busy, 0);
    scan4();

    for (int k = 0; k < 12; k++) begin
      blank_lz = 1'($urandom_range(0, 1));
      do_load(int'($urandom_range(0, 16383)));
      tick();
      scan4();
    end

    blink_en = 1'b1;
    do_load(int'($urandom_range(0, 9999)));
    for (int k = 0; k < 12; k++) begin
      clk_2hz = 1'($urandom_range(0, 1));
      tick();
      chk("blink_an", an, exp_an());
      scan_pulse();
    end
    blink_en = 1'b0;
    clk_2hz = 1'b1;
    tick();
    scan4();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/seven_seg_driver.md
Name: seven_seg_driver

Overview:
- Output-side display writer for the whack-a-mole datapath.
- Accepts a binary score/time value and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes four digits onto the Basys3 active-low seg/an pins using the divider's 500 Hz scan signal.
- Supports leading-zero blanking and 2 Hz whole-display blink for game-over/paused indication.

Parameters:
- DIGITS, 4, number of multiplexed digits; fixed at 4 for this board.
- BIN_W, 14, width of binary input value.
- MAX_VAL, 9999, largest displayable value; larger inputs clamp to this.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  synchronous, active-high reset
- clk_500hz  in  1  scan signal from clock_divider, a level; its rising edge advances the scan
- clk_2hz  in  1  blink signal from clock_divider, a level
- value  in  BIN_W  binary value to display
- load  in  1  one-cycle strobe; captures value when idle
- blank_lz  in  1  1 = suppress leading zeros
- blink_en  in  1  1 = blank all digits while clk_2hz is low
- seg  out  7  active-low segments, seg[0]=a … seg[6]=g
- an  out  DIGITS  active-low digit enables, an[0]=rightmost digit
- busy  out  1  conversion in progress
- overflow  out  1  sticky; last loaded value exceeded MAX_VAL

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values:
  - seg=7'b1111111, an=4'b1111, busy=0, overflow=0.
  - Displayed digit registers = 0; scan index = 0; FSM = IDLE.
  - Reset during CONVERT aborts the conversion; no digit commit occurs.
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE:
  - load=1 captures value. If value > MAX_VAL, capture MAX_VAL and set overflow=1; otherwise set overflow=0.
  - Transition to CONVERT and assert busy.
- CONVERT:
  - Exactly BIN_W (14) iterations, one per clk.
  - Each iteration: add 3 to every BCD nibble that is >= 5, then shift {bcd, bin} left by 1.
  - After the 14th iteration, go to COMMIT.
- COMMIT:
  - All four display digits are loaded in one cycle (atomic update; never a partially converted value).
  - busy deasserts and the FSM returns to IDLE.
- Latency: load sampled in cycle N → busy=1 in cycles N+1..N+15 → new digits visible and busy=0 from cycle N+16.
- load while busy is ignored; there is no queuing. load in the same cycle as rst is ignored.
- Scan:
  - A registered copy of clk_500hz is used to detect its rising edge. Each edge advances the index 0→1→2→3→0.
  - an drives the active-low one-hot of the index: index 0 → 4'b1110, index 3 → 4'b0111.
  - seg and an are registered and update in the same cycle, so there is no ghosting between digits.
- Segment codes (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- Leading-zero suppression (blank_lz=1): a digit is blanked if it and every higher digit are 0. Digit 0 is never blanked, so the value 0 shows "   0".
- Blink: when blink_en=1 and clk_2hz=0, an=4'b1111. The scan index keeps advancing during blink.
- blank_lz and blink_en are combinational qualifiers on the next registered output and take effect within 1 cycle.
- Display digits hold their last committed value until the next COMMIT.

Test Plan:
- Reset then idle: rst high 2 cycles → seg=1111111, an=1111, busy=0; after the first 500 Hz edge an=1110, seg=1000000 (digit "0").
- Conversion of 1234: load with value=1234 → busy high for exactly 15 cycles; over four scan edges an=1110/1101/1011/0111 with seg=0011001/0110000/0100100/1111001 (digits 4, 3, 2, 1).
- Overflow: value=12000 → overflow=1 and display 9999; a later load of 42 → overflow=0, display "0042", or "  42" with blank_lz=1 (an[3:2] scans show seg=1111111).
- Load while busy: load 5678, then load 1111 three cycles later → final display 5678 and only one busy pulse.
- Reset mid-operation: rst asserted in the 7th CONVERT cycle → busy=0 next cycle, digits 0, no commit of the partial value.
- Blink: blink_en=1 with clk_2hz toggling → an=1111 whenever clk_2hz=0, normal scan whenever clk_2hz=1.
